// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the register write-back arbiter: default widths,
// the write-back request record and a small sizing helper.
package reg_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;

  // One write-back request: destination register plus the value to write.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

  // Occupancy counter width able to represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// Circular FIFO holding queued source-B write-back requests.
// The head entry is presented combinationally so a pop in cycle t can be
// captured by the downstream output register at the end of that cycle.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Ignore illegal requests so the pointers can never overrun each other.
  assign do_push = push && (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop  && (count_q != '0);

  // Pointer and occupancy next state; pointers wrap naturally (power-of-two depth).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; storage contents are left alone by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates register-file write-back between the ALU (source A) and the
// queued measurement-result return path (source B). A has priority unless B
// has waited STARVE_MAX A grants; the chosen request is registered onto the
// write port one cycle later, and writes to r0 are swallowed.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [ADDR_W-1:0]             a_addr,
  input  logic [DATA_W-1:0]             a_data,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [ADDR_W-1:0]             b_addr,
  input  logic [DATA_W-1:0]             b_data,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int CNT_W = cnt_w(FIFO_DEPTH);
  localparam int SW    = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0]       count;
  logic [ADDR_W+DATA_W-1:0] head_data;
  logic [ADDR_W-1:0]      head_addr;
  logic                   b_pending, force_b, pop_b, grant_a, push_b;
  logic [SW-1:0]          starve_q, starve_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_b),
    .push_data ({b_addr, b_data}),
    .pop       (pop_b),
    .head_data (head_data),
    .count     (count)
  );

  assign head_addr = head_data[ADDR_W+DATA_W-1 -: ADDR_W];
  assign b_pending = (count != '0);
  assign force_b   = b_pending && (starve_q == SW'(STARVE_MAX));
  assign a_ready   = !force_b;
  assign b_ready   = (count != CNT_W'(FIFO_DEPTH));
  assign push_b    = b_valid && b_ready;
  assign pop_b     = b_pending && (force_b || !a_valid);
  assign grant_a   = !pop_b && a_valid && a_ready;

  // Grant selection, starvation tracking and write-port next state.
  always_comb begin
    starve_d  = starve_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pop_b || !b_pending) begin
      starve_d = '0;
    end else if (grant_a && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + SW'(1);
    end
    if (pop_b) begin
      wr_en_d   = (head_addr != '0);
      wr_addr_d = head_addr;
      wr_data_d = head_data[DATA_W-1:0];
    end else if (grant_a) begin
      wr_en_d   = (a_addr != '0);
      wr_addr_d = a_addr;
      wr_data_d = a_data;
    end
  end

  // Starvation counter and registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign fifo_count = count;
  assign busy       = b_pending || wr_en_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter at default parameters.
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr, wr_addr;
  logic [63:0] a_data, b_data, wr_data;
  logic        wr_en, busy;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_err    = 0;

  wb_req_t exp_q[$];
  wb_req_t r;

  reg_wb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .a_addr     (a_addr),
    .a_data     (a_data),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .b_addr     (b_addr),
    .b_data     (b_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] xaddr(input int n);
    return 5'((n % 30) + 1);
  endfunction

  initial begin
    reset = 1'b1; a_valid = 0; b_valid = 0;
    a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
    step(); step();
    reset = 1'b0;
    #1;
    // Reset state
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);
    chk("rst_busy", busy, 0);
    $display("reset: checks=%0d errors=%0d", n_checks, n_err);

    // Single A write
    a_valid = 1; a_addr = 5'd3; a_data = 64'h0123_4567_89AB_CDEF;
    #1 chk("a1_ready", a_ready, 1);
    step(); a_valid = 0;
    chk("a1_wr_en", wr_en, 1);
    chk("a1_wr_addr", wr_addr, 3);
    chk("a1_wr_data", wr_data, 64'h0123_4567_89AB_CDEF);
    step();
    chk("idle_wr_en", wr_en, 0);
    chk("idle_hold_addr", wr_addr, 3);
    chk("idle_hold_data", wr_data, 64'h0123_4567_89AB_CDEF);
    $display("a write addr 3: checks=%0d errors=%0d", n_checks, n_err);

    // Four consecutive B pushes, A idle: each write lands two cycles after its push
    for (int i = 0; i < 4; i++) begin
      b_valid = 1; b_addr = 5'(5 + i); b_data = 64'hB000_0000_0000_0000 + 64'(i);
      #1 chk("b4_b_ready", b_ready, 1);
      step();
      if (i == 0) chk("b4_no_bypass", wr_en, 0);
      else begin
        chk("b4_wr_en", wr_en, 1);
        chk("b4_wr_addr", wr_addr, 64'(5 + i - 1));
        chk("b4_wr_data", wr_data, 64'hB000_0000_0000_0000 + 64'(i - 1));
      end
      $display("b push addr %0d: wr_en=%0d wr_addr=%0d count=%0d", 5 + i, wr_en, wr_addr, fifo_count);
    end
    b_valid = 0;
    step();
    chk("b4_last_addr", wr_addr, 8);
    chk("b4_last_data", wr_data, 64'hB000_0000_0000_0003);
    step();
    chk("b4_drained_en", wr_en, 0);
    chk("b4_drained_cnt", fifo_count, 0);

    // Starvation: one B entry queued behind a continuous A stream
    a_valid = 1; a_addr = 5'd11; a_data = 64'hA11;
    b_valid = 1; b_addr = 5'd9; b_data = 64'hB9;
    #1 chk("st_a_ready0", a_ready, 1);
    step(); b_valid = 0;
    chk("st_wr_a11", wr_addr, 11);
    chk("st_count1", fifo_count, 1);
    for (int k = 0; k < 4; k++) begin
      a_addr = 5'(12 + k); a_data = 64'hA00 + 64'(12 + k);
      #1 chk("st_a_ready", a_ready, 1);
      step();
      chk("st_wr_en", wr_en, 1);
      chk("st_wr_addr", wr_addr, 64'(12 + k));
      $display("starve A grant %0d: wr_addr=%0d count=%0d", k + 1, wr_addr, fifo_count);
    end
    a_addr = 5'd16; a_data = 64'hA16;
    #1 chk("st_a_ready_forced", a_ready, 0);
    step();
    chk("st_wr_b_addr", wr_addr, 9);
    chk("st_wr_b_data", wr_data, 64'hB9);
    chk("st_count0", fifo_count, 0);
    #1 chk("st_a_ready_back", a_ready, 1);
    step();
    chk("st_resume_addr", wr_addr, 16);
    chk("st_resume_data", wr_data, 64'hA16);
    a_valid = 0;
    step();

    // Writes to r0 from either source are consumed without a strobe
    a_valid = 1; a_addr = 5'd0; a_data = '1;
    #1 chk("r0a_ready", a_ready, 1);
    step(); a_valid = 0;
    chk("r0a_wr_en", wr_en, 0);
    b_valid = 1; b_addr = 5'd0; b_data = '1;
    step(); b_valid = 0;
    chk("r0b_count1", fifo_count, 1);
    step();
    chk("r0b_count0", fifo_count, 0);
    chk("r0b_wr_en", wr_en, 0);
    $display("r0 writes: checks=%0d errors=%0d", n_checks, n_err);

    // Fill the queue to 4 under an r0 A stream, then reset with B still valid
    a_valid = 1; a_addr = 5'd0; a_data = 64'h5;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1; b_addr = 5'(20 + i); b_data = 64'hDEAD + 64'(i);
      step();
    end
    chk("full_count", fifo_count, 4);
    chk("full_b_ready", b_ready, 0);
    chk("full_wr_en", wr_en, 0);
    reset = 1; a_valid = 0;
    step();
    reset = 0; b_valid = 0;
    #1;
    chk("mr_count", fifo_count, 0);
    chk("mr_wr_en", wr_en, 0);
    chk("mr_b_ready", b_ready, 1);
    chk("mr_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_no_stale", wr_en, 0);
    end
    $display("mid reset: checks=%0d errors=%0d", n_checks, n_err);

    // Hold count at 2 with simultaneous push and pop across pointer wraps
    a_valid = 1; a_addr = 5'd0; a_data = 64'h0;
    for (int n = 0; n < 2; n++) begin
      b_valid = 1; b_addr = xaddr(n); b_data = 64'hC000 + 64'(n);
      r.addr = b_addr; r.data = b_data; exp_q.push_back(r);
      step();
    end
    a_valid = 0;
    chk("pp_count_start", fifo_count, 2);
    for (int j = 0; j < 10; j++) begin
      b_valid = 1; b_addr = xaddr(j + 2); b_data = 64'hC000 + 64'(j + 2);
      r.addr = b_addr; r.data = b_data; exp_q.push_back(r);
      step();
      r = exp_q.pop_front();
      chk("pp_count", fifo_count, 2);
      chk("pp_wr_en", wr_en, 1);
      chk("pp_wr_addr", wr_addr, 64'(r.addr));
      chk("pp_wr_data", wr_data, r.data);
      $display("push/pop %0d: wr_addr=%0d count=%0d", j, wr_addr, fifo_count);
    end
    b_valid = 0;
    for (int j = 0; j < 2; j++) begin
      step();
      r = exp_q.pop_front();
      chk("pp_drain_addr", wr_addr, 64'(r.addr));
      chk("pp_drain_data", wr_data, r.data);
    end
    chk("pp_final_count", fifo_count, 0);
    step();
    chk("pp_final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
